// File: rtl/seq_circuit_pkg.sv
// Shared types for the 2-bit up/down sequencer.
// Terminal state is the one flagged on Y.
package seq_circuit_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam state_t TERM_STATE = S3;

endpackage

// File: rtl/seq_circuit.sv
// Modulo-4 up/down Moore sequencer.
// A=0 counts up, A=1 counts down; Y flags the terminal state.
module seq_circuit
    import seq_circuit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    output logic Y
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = A ? S3 : S1;
            S1:      state_d = A ? S0 : S2;
            S2:      state_d = A ? S1 : S3;
            S3:      state_d = A ? S2 : S0;
            default: state_d = S0;
        endcase
    end

    // Moore decode: depends on the registered state only
    always_comb begin
        Y = 1'b0;
        if (state_q == TERM_STATE) begin
            Y = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_circuit.sv
// Directed bench for seq_circuit.
// Checks Y and the state register against hand-computed values.
module tb_seq_circuit;

    logic clk;
    logic rst_n;
    logic A;
    logic Y;

    int checks;
    int failures;
    int y_high;

    seq_circuit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] exp_s);
        logic exp_y;
        logic [1:0] obs_s;
        exp_y = (exp_s == 2'b11);
        obs_s = dut.state_q;
        checks++;
        assert (Y === exp_y) else begin
            failures++;
            $error("FAIL %s Y observed=%b expected=%b", tag, Y, exp_y);
        end
        checks++;
        assert (obs_s === exp_s) else begin
            failures++;
            $error("FAIL %s state observed=%b expected=%b",
                   tag, obs_s, exp_s);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] exp_s);
        @(posedge clk);
        #1;
        check(tag, exp_s);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        y_high   = 0;
        rst_n    = 1'b0;
        A        = 1'b1;

        #2;
        check("reset", 2'b00);
        #3;
        rst_n = 1'b1;

        // count down with wrap from S0
        step("dn_10", 2'b11);
        step("dn_30", 2'b10);
        step("dn_50", 2'b01);
        step("dn_70", 2'b00);

        #4;
        A = 1'b0;
        step("up_90", 2'b01);
        step("up_110", 2'b10);

        #4;
        A = 1'b1;
        step("rev_130", 2'b01);
        step("rev_150", 2'b00);
        step("rev_170", 2'b11);
        step("rev_190", 2'b10);

        // up to S3, then wrap up to S0
        #4;
        A = 1'b0;
        step("to_s3", 2'b11);
        step("wrap_up", 2'b00);

        // four up edges from S0 return to S0
        step("lap_1", 2'b01);
        if (Y) y_high++;
        step("lap_2", 2'b10);
        if (Y) y_high++;
        step("lap_3", 2'b11);
        if (Y) y_high++;
        step("lap_4", 2'b00);
        if (Y) y_high++;
        checks++;
        assert (y_high == 1) else begin
            failures++;
            $error("FAIL lap_y_cycles observed=%0d expected=1", y_high);
        end

        // glitch on A between edges must not matter
        #4;
        A = 1'b1;
        #4;
        A = 1'b0;
        step("glitch", 2'b01);

        step("pre_rst_a", 2'b10);
        step("pre_rst_b", 2'b11);

        // async reset between edges from S3
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst", 2'b00);
        step("rst_hold", 2'b00);
        #4;
        rst_n = 1'b1;
        A = 1'b0;
        step("post_rst", 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_circuit.md
Name: seq_circuit

Overview:
- Two-bit Moore state machine driven by a single control input A; it acts as a modulo-4 up/down counter.
- A=0 counts up and A=1 counts down.
- Output Y flags the terminal state 2'b11.
- Small control leaf used wherever a 2-bit cyclic sequencer with a terminal-state flag is needed.

Parameters:
- None. The state width is fixed at 2 bits.

Ports:
- clk    input  1  System clock. All state updates occur on the rising edge.
- rst_n  input  1  Reset. Asynchronous, active-low.
- A      input  1  Direction control. 0 = count up, 1 = count down. Sampled on the rising clk edge.
- Y      output 1  High while the current state is 2'b11 (Q1=1, Q0=1).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- State register {Q1,Q0}, 2 bits. Encoding: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
- Reset:
  - rst_n low forces the state to S0 immediately, with no clock edge required.
  - Y=0 during reset.
  - While rst_n is low, edges on clk are ignored.
  - On release, the first rising clk edge with rst_n high performs a normal transition.
- Next-state table, written as current --A=0--> next, --A=1--> next:
  - S0: A=0 -> S1; A=1 -> S3
  - S1: A=0 -> S2; A=1 -> S0
  - S2: A=0 -> S3; A=1 -> S1
  - S3: A=0 -> S0; A=1 -> S2
- Equivalent arithmetic: next = state + 1 when A=0, next = state - 1 when A=1, both mod 4. Wrap-around in both directions is required: S3 up goes to S0, S0 down goes to S3.
- Output is Moore: Y = Q1 & Q0. It is a combinational decode of the registered state only and does not depend on A directly.
  - Y changes only after a rising clk edge or on asynchronous reset assertion.
  - The latency from the A sample to the Y change is one clock edge.
- A is sampled only at the rising clk edge. Glitches on A between edges have no effect.
- No illegal states exist, since all 4 encodings are reachable and handled. A default branch shall still map to S0.
- Reset asserted mid-sequence, from any state, returns to S0 and Y=0 asynchronously.

Decomposition:
- Shared package seq_circuit_pkg:
  - enum typedef state_t (2 bits: S0, S1, S2, S3)
  - constant TERM_STATE = S3
- Module structure: a three-block FSM style.
  - state register with async reset
  - combinational next-state case table
  - output decode
- No sub-module is warranted; the block stays a single module.

Test Plan:
- Reset and async behaviour: rst_n=0 at t=0 with A=1, released at 5ns. Clock period is 20ns, first rising edge at 10ns. Required: state=S0 and Y=0 before 5ns. Asserting rst_n=0 between clock edges must force S0 and Y=0 at once, without waiting for an edge.
- Count down with wrap: hold A=1 from release. Required states after the edges at 10/30/50/70ns: S3, S2, S1, S0. Y=1 only in the 10–30ns window.
- Count up: A=0 from 75ns to 115ns. Required edges: 90ns -> S1, 110ns -> S2. Y=0 throughout.
- Direction reversal and downward wrap: A=1 again from 115ns. Required edges: 130ns -> S1, 150ns -> S0, 170ns -> S3 (Y=1), 190ns -> S2 (Y=0).
- Upward wrap: from S3, apply A=0 for one edge. Required: S0 and Y falls to 0. Four consecutive A=0 edges starting from S0 must return to S0, with Y high for exactly one cycle.
- Reset mid-operation: from S3 (Y=1), drop rst_n between edges. Required: Y drops to 0 immediately and the state reads S0. After release, the first A=0 edge gives S1.
